// File: rtl/axi_lite_master_pkg.sv
// Shared AXI-lite definitions and master FSM types.
//   - AXI bus-width macros and response encodings (guarded, global to the
//     compilation unit so every AXI block sees the same values).
//   - axi_mst_state_t: state encoding of the single-outstanding master,
//     shared so IFU/LSU logic can decode master status.
//   - is_wait_state(): states in which the master waits on the slave.

`ifndef AXI_DEFINES_SVH
`define AXI_DEFINES_SVH
`define AXI_ADDR_BUS    31:0
`define AXI_DATA_BUS    31:0
`define AXI_WSTRB_BUS   3:0
`define AXI_RESP_BUS    1:0
`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_SLVERR 2'b10
`endif

package axi_lite_master_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RD_ADDR      = 3'd1,
    RD_DATA      = 3'd2,
    WR_ADDR_DATA = 3'd3,
    WR_RESP      = 3'd4,
    RESP         = 3'd5
  } axi_mst_state_t;

  // States in which progress depends on the slave; the watchdog runs here.
  function automatic logic is_wait_state(input axi_mst_state_t s);
    return (s == RD_ADDR) || (s == RD_DATA) ||
           (s == WR_ADDR_DATA) || (s == WR_RESP);
  endfunction

endpackage

// File: rtl/axi_lite_master.sv
// AXI-lite initiator bridging a single-beat core request/response port.
// One transaction outstanding at a time; a sticky watchdog flags a slave
// that stalls in any wait state for TIMEOUT_CYCLES cycles (0 disables it).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           core request handshake (req_ready = IDLE)
//   req_we/req_addr/req_wdata/req_wstrb  request payload
//   resp_valid/resp_ready         core response handshake
//   resp_rdata/resp_err           response payload (rdata 0 for writes)
//   timeout                       sticky watchdog flag
//   ar*/r*/aw*/w*/b*              AXI-lite initiator channels

module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [`AXI_ADDR_BUS]  req_addr,
  input  logic [`AXI_DATA_BUS]  req_wdata,
  input  logic [`AXI_WSTRB_BUS] req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [`AXI_DATA_BUS]  resp_rdata,
  output logic                  resp_err,
  output logic                  timeout,
  output logic [`AXI_ADDR_BUS]  araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [`AXI_DATA_BUS]  rdata,
  input  logic [`AXI_RESP_BUS]  rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [`AXI_ADDR_BUS]  awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [`AXI_DATA_BUS]  wdata,
  output logic [`AXI_WSTRB_BUS] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [`AXI_RESP_BUS]  bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  // Watchdog counts 0..TIMEOUT_CYCLES-1 and then parks at the top value.
  localparam int unsigned WD_LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned WD_W     = (WD_LIMIT > 1) ? $clog2(WD_LIMIT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);

  axi_mst_state_t         state_q, state_d;
  logic [`AXI_ADDR_BUS]   addr_q, addr_d;
  logic [`AXI_DATA_BUS]   wdata_q, wdata_d;
  logic [`AXI_WSTRB_BUS]  wstrb_q, wstrb_d;
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q, rready_d;
  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   bready_q, bready_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [`AXI_DATA_BUS]   resp_rdata_q, resp_rdata_d;
  logic                   resp_err_q, resp_err_d;
  logic                   timeout_q, timeout_d;
  logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign ar_hs = arvalid_q && arready;
  assign r_hs  = rvalid && rready_q;
  assign aw_hs = awvalid_q && awready;
  assign w_hs  = wvalid_q && wready;
  assign b_hs  = bvalid && bready_q;

  assign req_ready  = (state_q == IDLE);
  assign araddr     = addr_q;
  assign awaddr     = addr_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign awvalid    = awvalid_q;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign timeout    = timeout_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    timeout_d    = timeout_q;
    wd_cnt_d     = wd_cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          resp_rdata_d = rdata;
          resp_err_d   = (rresp != `AXI_RESP_OKAY);
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      WR_ADDR_DATA: begin
        // AW and W complete independently; move on once both have.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          resp_err_d   = (bresp != `AXI_RESP_OKAY);
          resp_rdata_d = '0;
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        arvalid_d    = 1'b0;
        rready_d     = 1'b0;
        awvalid_d    = 1'b0;
        wvalid_d     = 1'b0;
        bready_d     = 1'b0;
        resp_valid_d = 1'b0;
      end
    endcase

    // Watchdog: restart on entering a wait state, count while in one.
    if (is_wait_state(state_d) && (state_d != state_q)) begin
      wd_cnt_d = '0;
    end else if (is_wait_state(state_q) && (wd_cnt_q != WD_MAX)) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    if ((TIMEOUT_CYCLES != 0) && is_wait_state(state_q) && (wd_cnt_q == WD_MAX)) begin
      timeout_d = 1'b1;
    end
  end

  // ---- register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      timeout_q    <= timeout_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: the slave side is played cycle by
// cycle from a single initial block, with a small word memory standing in
// for the SRAM. Inputs change and outputs are sampled on the falling edge.

module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err, timeout;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  logic [31:0] mem [0:15];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .timeout(timeout),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called on the falling edge where resp_valid should first be high.
  task automatic finish_resp(input int hold, input logic [31:0] exp_rdata, input logic exp_err);
    chk("resp_valid_up", resp_valid, 1);
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("resp_err", resp_err, exp_err);
    chk("req_ready_busy", req_ready, 0);
    if (hold > 0) begin
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_addr   = 32'h8000_0000;
    end else begin
      resp_ready = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, exp_rdata);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_no_ar", arvalid, 0);
      if (i == hold - 1) begin
        resp_ready = 1'b1;
        req_valid  = 1'b0;
      end
    end
    @(negedge clk);
    chk("resp_valid_down", resp_valid, 0);
    chk("req_ready_idle", req_ready, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_delay, input int r_delay,
                         input logic [1:0] rresp_v, input logic [31:0] exp_rdata,
                         input logic exp_err, input int hold);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = addr;
    chk("rd_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("arvalid_up", arvalid, 1);
    chk("araddr", araddr, addr);
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clk);
      chk("arvalid_hold", arvalid, 1);
      chk("araddr_hold", araddr, addr);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("arvalid_drop", arvalid, 0);
    chk("rready_up", rready, 1);
    for (int i = 0; i < r_delay; i++) begin
      @(negedge clk);
      chk("rready_hold", rready, 1);
    end
    rvalid = 1'b1;
    rdata  = mem[addr[5:2]];
    rresp  = rresp_v;
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = 32'h0;
    rresp  = 2'b00;
    chk("rready_drop", rready, 0);
    finish_resp(hold, exp_rdata, exp_err);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int w_delay, input logic [1:0] bresp_v,
                          input logic [31:0] exp_mem);
    logic aw_seen, w_seen;
    int c;
    logic [3:0] idx;
    idx = addr[5:2];
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    req_wstrb = strb;
    chk("wr_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    aw_seen = 1'b0;
    w_seen  = 1'b0;
    c = 0;
    while (!(aw_seen && w_seen)) begin
      chk("awvalid", awvalid, !aw_seen);
      chk("wvalid", wvalid, !w_seen);
      chk("awaddr", awaddr, addr);
      if (!w_seen) begin
        chk("wdata", wdata, data);
        chk("wstrb", wstrb, strb);
      end
      awready = (c == aw_delay);
      wready  = (c == w_delay);
      if (c == w_delay) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
      @(negedge clk);
      if (awready) aw_seen = 1'b1;
      if (wready)  w_seen  = 1'b1;
      awready = 1'b0;
      wready  = 1'b0;
      c++;
    end
    chk("bready_up", bready, 1);
    chk("awvalid_done", awvalid, 0);
    chk("wvalid_done", wvalid, 0);
    chk("mem_word", mem[idx], exp_mem);
    bvalid = 1'b1;
    bresp  = bresp_v;
    @(negedge clk);
    bvalid = 1'b0;
    bresp  = 2'b00;
    chk("bready_drop", bready, 0);
    finish_resp(0, 32'h0, bresp_v != 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL bench_time_limit: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int d1, d2;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'hDEAD_BEEF;
    mem[1] = 32'h1111_2222;
    mem[4] = 32'hAAAA_AAAA;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
    resp_ready = 1'b1;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_araddr", araddr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Read with random slave delays, response taken immediately.
    d1 = $urandom_range(0, 3);
    d2 = $urandom_range(0, 3);
    do_read(32'h8000_0000, d1, d2, 2'b00, 32'hDEAD_BEEF, 1'b0, 0);

    // Write with AW and W accepted together; only bytes [1:0] change.
    do_write(32'h8000_0010, 32'h1234_5678, 4'b0011, 0, 0, 2'b00, 32'hAAAA_5678);

    // Write with AW accepted 3 cycles before W.
    do_write(32'h8000_0020, 32'hCAFE_F00D, 4'b1111, 0, 3, 2'b00, 32'hCAFE_F00D);

    // W accepted before AW.
    do_write(32'h8000_0030, 32'h0BAD_F00D, 4'b1100, 2, 0, 2'b00, 32'h0BAD_0000);

    // SLVERR read, then OKAY read of the partially written word.
    do_read(32'h8000_0004, 1, 0, 2'b10, 32'h1111_2222, 1'b1, 0);
    do_read(32'h8000_0010, 0, 1, 2'b00, 32'hAAAA_5678, 1'b0, 0);

    // SLVERR on a write response.
    do_write(32'h8000_0014, 32'h5555_6666, 4'b1111, 1, 1, 2'b10, 32'h5555_6666);

    // Core holds resp_ready low for 5 cycles.
    do_read(32'h8000_0020, 0, 0, 2'b00, 32'hCAFE_F00D, 1'b0, 5);

    // Slave never returns read data: watchdog fires after 8 cycles in RD_DATA.
    chk("timeout_pre", timeout, 0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h8000_0004;
    @(negedge clk);
    req_valid = 1'b0;
    arready   = 1'b1;
    @(negedge clk);
    arready   = 1'b0;
    chk("to_rready", rready, 1);
    for (int k = 0; k < 8; k++) begin
      chk("to_not_yet", timeout, 0);
      @(negedge clk);
    end
    chk("to_set", timeout, 1);
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("to_sticky", timeout, 1);
    chk("to_still_waiting", rready, 1);
    chk("to_no_resp", resp_valid, 0);

    // Asynchronous reset in the middle of the stalled read.
    rst = 1'b1;
    #1;
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_resp_rdata", resp_rdata, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_araddr", araddr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Normal operation after reset.
    do_read(32'h8000_0000, 0, 0, 2'b00, 32'hDEAD_BEEF, 1'b0, 0);
    chk("post_rst_timeout", timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Bridges a simple core-side single-beat request/response port (IFU/LSU side) onto an AXI-lite initiator interface.
- It is the requesting end of the same AXI-lite channel set that the memory/peripheral slaves respond on.
- Only one transaction is outstanding at a time.
- Includes a watchdog that flags a slave which never responds.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles allowed in any AXI wait state before the sticky timeout flag sets; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  master can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address (`AXI_ADDR_BUS).
- req_wdata  in  32  write data (`AXI_DATA_BUS).
- req_wstrb  in  4  byte strobes (`AXI_WSTRB_BUS); ignored for reads.
- resp_valid  out  1  response available.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  32  read data; 0 for writes.
- resp_err  out  1  slave returned a non-OKAY response.
- timeout  out  1  sticky watchdog flag.
- araddr/arvalid out, arready in: AR channel.
- rdata(32)/rresp(2)/rvalid in, rready out: R channel.
- awaddr/awvalid out, awready in: AW channel.
- wdata(32)/wstrb(4)/wvalid out, wready in: W channel.
- bresp(2)/bvalid in, bready out: B channel.

Behaviour:
- Reset values (asynchronous): state IDLE; all AXI valid/ready outputs 0; resp_valid 0; resp_rdata 0; resp_err 0; timeout 0; address/data registers 0.
- req_ready = (state == IDLE), combinational. Every other output is registered.
- IDLE:
  - On req_valid && req_ready, latch addr/wdata/wstrb/we.
  - Write: go to WR_ADDR_DATA; awvalid and wvalid both 1 the next cycle.
  - Read: go to RD_ADDR; arvalid 1 the next cycle.
- RD_ADDR:
  - arvalid held and araddr stable until arvalid && arready.
  - On that handshake: arvalid goes 0, rready goes 1, state goes to RD_DATA.
- RD_DATA:
  - On rvalid && rready: capture rdata into resp_rdata and set resp_err = (rresp != 2'b00).
  - rready goes 0; go to RESP.
- WR_ADDR_DATA:
  - AW and W are independent. Each valid is held until its own handshake, then dropped; aw_done/w_done are tracked.
  - Both handshakes may occur in the same cycle, or in either order.
  - When both are done (including the cycle the last one completes): bready goes 1, state goes to WR_RESP.
- WR_RESP:
  - On bvalid && bready: resp_err = (bresp != 2'b00), resp_rdata = 0, bready goes 0, go to RESP.
- RESP:
  - resp_valid = 1, held with resp_rdata/resp_err stable until resp_ready.
  - Then resp_valid goes 0 and state goes to IDLE.
  - A new request is accepted no earlier than the cycle after that.
- Latency: with a zero-wait slave, a read takes acceptance T0, AR handshake T1, R handshake T2, resp_valid T3.
- Payload rule: AXI payload outputs never change while their valid is high without a handshake.
- Watchdog:
  - A counter clears on entry to any of RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES-1, timeout sets and stays set until rst.
  - The FSM is not altered by a timeout; the transaction keeps waiting.
  - The counter saturates and does not wrap.
- Reset mid-transaction: everything returns to reset values immediately; the outstanding AXI transaction is abandoned.
- Unused state encodings go to IDLE.

Decomposition:
- AXI bus width macros and the OKAY/SLVERR response encodings come from the shared defines include, alongside the existing `AXI_*_BUS macros.
- A state enum typedef (IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESP) goes in the shared package for reuse by IFU/LSU.
- No sub-module: a single module, roughly 200 lines.

Test Plan:
- Read 0x8000_0000 against a random-delay SRAM slave returning 0xDEADBEEF, resp_ready tied high -> one resp_valid pulse, resp_rdata = 0xDEADBEEF, resp_err = 0, arvalid dropped in the cycle after the handshake.
- Write addr 0x8000_0010, data 0x1234_5678, wstrb 4'b0011, slave requiring AW and W in the same cycle -> aw/w handshake together, bready asserted, resp_valid with resp_rdata = 0, memory bytes [1:0] = 0x5678.
- Slave raises awready 3 cycles before wready -> awvalid drops after its handshake, wvalid held with wdata stable, exactly one B handshake, then response.
- Slave returns rresp = 2'b10 -> resp_err = 1; next transaction with OKAY -> resp_err = 0.
- resp_ready held low for 5 cycles -> resp_valid/resp_rdata stable, req_ready = 0 throughout, next request accepted only after the resp handshake.
- TIMEOUT_CYCLES = 8, slave never asserts rvalid -> timeout = 1 after 8 cycles in RD_DATA; assert rst mid-wait -> all outputs at reset values, timeout = 0, req_ready = 1.
